// File: rtl/pipeline_pkg.sv
// Shared constants and stage bundle types for the front-end
// pipeline registers.
package pipeline_pkg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 8;

    localparam logic [DW-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int CTRL_MEMREAD_BIT = 0;

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
        logic          valid;
    } if_id_t;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic [DW-1:0] pc;
        logic          valid;
    } id_ex_t;

endpackage

// File: rtl/pipeline_stage_ctrl_if.sv
// Hazard-control and stage-register bundle for pipeline_stage_ctrl.
// Stall_Count exists only when STALL_COUNTER_EN is defined.
interface pipeline_stage_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  PCWrite;
    logic                  IDWrite;
    logic                  Stall;
    logic                  Flush;
    logic [DATA_WIDTH-1:0] PC_Next;
    logic [DATA_WIDTH-1:0] F_Instr;
    logic [CTRL_WIDTH-1:0] D_Ctrl;
    logic [REG_WIDTH-1:0]  D_Rs1;
    logic [REG_WIDTH-1:0]  D_Rs2;
    logic [REG_WIDTH-1:0]  D_Rd;

    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] D_Instr;
    logic [DATA_WIDTH-1:0] D_PC;
    logic                  D_Valid;
    logic [CTRL_WIDTH-1:0] E_Ctrl;
    logic [REG_WIDTH-1:0]  E_Rs1;
    logic [REG_WIDTH-1:0]  E_Rs2;
    logic [REG_WIDTH-1:0]  E_Rd;
    logic [DATA_WIDTH-1:0] E_PC;
    logic                  E_Valid;
    logic                  E_MemRead;
`ifdef STALL_COUNTER_EN
    logic [CNT_WIDTH-1:0]  Stall_Count;
`endif

    modport master (
        output PCWrite, IDWrite, Stall, Flush,
        output PC_Next, F_Instr,
        output D_Ctrl, D_Rs1, D_Rs2, D_Rd,
        input  PC, D_Instr, D_PC, D_Valid,
        input  E_Ctrl, E_Rs1, E_Rs2, E_Rd,
        input  E_PC, E_Valid, E_MemRead
`ifdef STALL_COUNTER_EN
        , input Stall_Count
`endif
    );

    modport slave (
        input  PCWrite, IDWrite, Stall, Flush,
        input  PC_Next, F_Instr,
        input  D_Ctrl, D_Rs1, D_Rs2, D_Rd,
        output PC, D_Instr, D_PC, D_Valid,
        output E_Ctrl, E_Rs1, E_Rs2, E_Rd,
        output E_PC, E_Valid, E_MemRead
`ifdef STALL_COUNTER_EN
        , output Stall_Count
`endif
    );

endinterface

// File: rtl/pipeline_stage_ctrl_pipe_reg.sv
// Generic enable/clear register; clear and reset both load RESET_VAL,
// clear taking priority over enable.
module pipe_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// PC, IF/ID and ID/EX registers with hold, bubble and flush control.
// Define STALL_COUNTER_EN to add the saturating Stall_Count output.
module pipeline_stage_ctrl
    import pipeline_pkg::*;
#(
    parameter int                   DATA_WIDTH = DW,
    parameter int                   REG_WIDTH  = RW,
    parameter int                   CTRL_WIDTH = CW,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0040_0000,
    parameter int                   CNT_WIDTH  = 16
) (
    input logic clk,
    input logic rst_n,
    pipeline_stage_ctrl_if.slave bus
);

    localparam if_id_t IF_ID_RST = '{
        instr: NOP_INSTR, pc: '0, valid: 1'b0
    };

    logic [DATA_WIDTH-1:0] pc_q;
    if_id_t                if_id_d, if_id_q;
    id_ex_t                id_ex_d, id_ex_q;

    pipe_reg #(
        .WIDTH     (DATA_WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.Flush | bus.PCWrite),
        .clr   (1'b0),
        .d     (bus.PC_Next),
        .q     (pc_q)
    );

    always_comb begin
        if_id_d       = IF_ID_RST;
        if_id_d.instr = bus.F_Instr;
        if_id_d.pc    = pc_q;
        if_id_d.valid = 1'b1;
    end

    // Flush clears to the reset image: NOP, invalid, PC don't-care.
    pipe_reg #(
        .WIDTH     ($bits(if_id_t)),
        .RESET_VAL (IF_ID_RST)
    ) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.IDWrite),
        .clr   (bus.Flush),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    always_comb begin
        id_ex_d       = '0;
        id_ex_d.ctrl  = if_id_q.valid ? bus.D_Ctrl : '0;
        id_ex_d.rs1   = bus.D_Rs1;
        id_ex_d.rs2   = bus.D_Rs2;
        id_ex_d.rd    = bus.D_Rd;
        id_ex_d.pc    = if_id_q.pc;
        id_ex_d.valid = if_id_q.valid;
    end

    pipe_reg #(
        .WIDTH     ($bits(id_ex_t)),
        .RESET_VAL ('0)
    ) u_id_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (bus.Flush | bus.Stall),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    assign bus.PC        = pc_q;
    assign bus.D_Instr   = if_id_q.instr;
    assign bus.D_PC      = if_id_q.pc;
    assign bus.D_Valid   = if_id_q.valid;
    assign bus.E_Ctrl    = id_ex_q.ctrl;
    assign bus.E_Rs1     = id_ex_q.rs1;
    assign bus.E_Rs2     = id_ex_q.rs2;
    assign bus.E_Rd      = id_ex_q.rd;
    assign bus.E_PC      = id_ex_q.pc;
    assign bus.E_Valid   = id_ex_q.valid;
    assign bus.E_MemRead =
        id_ex_q.ctrl[CTRL_MEMREAD_BIT] & id_ex_q.valid;

`ifdef STALL_COUNTER_EN
    logic [CNT_WIDTH-1:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.Stall && !bus.Flush && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.Stall_Count = stall_cnt;
`endif

endmodule
